// File: rtl/cv32e40p_ded_collector.sv
// Register-file double-error collector: edge-detects the three RF DED levels into
// sticky status bits and saturating counters, raises a level irq, and exposes an OBI-style slave.
module cv32e40p_ded_collector #(
    parameter int unsigned CNT_WIDTH  = 8,
    parameter logic [2:0]  IRQ_EN_RST = 3'b111
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  ded_i,
    output logic        irq_o,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [4:0]  addr_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [2:0]             ded_q;
    logic [2:0]             ded_sts_q, ded_sts_d;
    logic [2:0]             sat_q, sat_d;
    logic [2:0]             en_q, en_d;
    logic                   irq_q, irq_d;
    logic                   rvalid_q, rvalid_d;
    logic [31:0]            rdata_q, rdata_d;

    logic                   accept;
    logic                   wr;
    logic                   rd;
    logic [2:0]             word_idx;
    logic                   wr_status;
    logic                   wr_ctrl;
    logic [2:0]             ev;
    logic [2:0]             cnt_clr;
    logic [2:0]             sat_ev;
    logic [2:0]             w1c_ded;
    logic [2:0]             w1c_sat;
    logic [3*CNT_WIDTH-1:0] cnt_all;
    logic                   unused_bits;

    assign accept    = req_i & ~rst_i;
    assign gnt_o     = accept;
    assign wr        = accept & we_i;
    assign rd        = accept & ~we_i;
    assign word_idx  = addr_i[4:2];
    assign wr_status = wr && (word_idx == 3'd0);
    assign wr_ctrl   = wr && (word_idx == 3'd1);
    assign w1c_ded   = wr_status ? wdata_i[2:0] : 3'b000;
    assign w1c_sat   = wr_status ? wdata_i[6:4] : 3'b000;
    assign ev        = ded_i & ~ded_q;

    assign unused_bits = ^{addr_i[1:0], wdata_i[31:7], wdata_i[3]};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [CNT_WIDTH-1:0] cnt_q;
            logic [CNT_WIDTH-1:0] cnt_d;
            logic                 at_max;

            assign cnt_clr[gi] = wr && (word_idx == 3'(gi + 2));
            assign at_max      = (cnt_q == CNT_MAX);
            // A clear coinciding with an event leaves exactly that one event counted.
            assign sat_ev[gi]  = ev[gi] & ~cnt_clr[gi] & at_max;
            assign cnt_d       = cnt_clr[gi] ? (ev[gi] ? CNT_ONE : '0)
                               : (ev[gi] && !at_max) ? cnt_q + CNT_ONE
                               : cnt_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_all[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        end
    endgenerate

    always_comb begin
        // New set conditions are OR-ed in after the clear, so a coincident set wins.
        ded_sts_d = (ded_sts_q & ~w1c_ded) | ev;
        sat_d     = (sat_q & ~w1c_sat) | sat_ev;
        en_d      = wr_ctrl ? wdata_i[2:0] : en_q;
        irq_d     = |(ded_sts_d & en_d);
        rvalid_d  = accept;
        rdata_d   = '0;
        if (rd) begin
            case (word_idx)
                3'd0:    rdata_d = {25'd0, sat_q, 1'b0, ded_sts_q};
                3'd1:    rdata_d = {29'd0, en_q};
                3'd2:    rdata_d = 32'(cnt_all[0*CNT_WIDTH +: CNT_WIDTH]);
                3'd3:    rdata_d = 32'(cnt_all[1*CNT_WIDTH +: CNT_WIDTH]);
                3'd4:    rdata_d = 32'(cnt_all[2*CNT_WIDTH +: CNT_WIDTH]);
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ded_q     <= '0;
            ded_sts_q <= '0;
            sat_q     <= '0;
            en_q      <= IRQ_EN_RST;
            irq_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ded_q     <= ded_i;
            ded_sts_q <= ded_sts_d;
            sat_q     <= sat_d;
            en_q      <= en_d;
            irq_q     <= irq_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign irq_o = irq_q;
    // A response pending when reset arrives is suppressed rather than delivered.
    assign rvalid_o = rvalid_q & ~rst_i;
    assign rdata_o  = rst_i ? 32'd0 : rdata_q;

endmodule
